// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one valid/ready pipeline stage register with a saturating
// back-pressure (stall) counter.
//
// Build option PIPE_SKID_EN:
//   defined   - 2-entry skid buffer (main + skid register, states EMPTY/ONE/TWO);
//               in_ready is decoded from registers only, so there is no
//               combinational path from out_ready to in_ready.
//   undefined - single register; in_ready = !out_valid || out_ready
//               (combinational), full throughput when out_ready=1.
//
// out_valid/out_data always come straight from registers. reset is
// asynchronous and active-low; flush is a synchronous kill that has priority
// over both the in-side and out-side transfer of the same cycle.
module pipe_stage_reg #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;

    // Stall counter next value: count edges where a valid output is held off, saturating at all-ones.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !flush && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Stall counter register; only reset clears it, flush does not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign out_data  = main_data_q;

`ifdef PIPE_SKID_EN

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // State register plus main/skid payload registers; reset clears all of them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Next-state logic: flush empties the buffer regardless of any handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (in_valid) state_d = S_ONE;
                S_ONE: begin
                    if (in_valid && !out_ready)      state_d = S_TWO;
                    else if (!in_valid && out_ready) state_d = S_EMPTY;
                end
                S_TWO:   if (out_ready) state_d = S_ONE;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Outputs and payload moves: in_ready is a pure state decode; in TWO nothing is accepted.
    always_comb begin
        in_ready    = (state_q != S_TWO);
        out_valid   = (state_q != S_EMPTY);
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (!flush) begin
            case (state_q)
                S_EMPTY: if (in_valid) main_data_d = in_data;
                S_ONE: begin
                    if (in_valid && out_ready) main_data_d = in_data;
                    else if (in_valid)         skid_data_d = in_data;
                end
                S_TWO:   if (out_ready) main_data_d = skid_data_q;
                default: ;
            endcase
        end
    end

`else

    logic valid_q, valid_d;

    // Single valid bit plus payload register; reset clears both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            main_data_q <= '0;
        end else begin
            valid_q     <= valid_d;
            main_data_q <= main_data_d;
        end
    end

    // Ready whenever the register is empty or is being drained this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;

    // Next valid/payload: flush wins, then an accepted input, then a drain.
    always_comb begin
        valid_d     = valid_q;
        main_data_d = main_data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            valid_d     = 1'b1;
            main_data_d = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. Two instances share the stimulus:
// dut (WIDTH=64, CNT_W=32) and dut3 (WIDTH=16, CNT_W=3) for stall saturation.
// Skid-specific back-pressure expectations are selected with PIPE_SKID_EN.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [31:0] stall_cnt;

    logic [15:0] in_data16;
    logic        in_ready3;
    logic        out_valid3;
    logic [15:0] out_data3;
    logic [2:0]  stall_cnt3;

    int total;
    int bad;

    assign in_data16 = in_data[15:0];

    pipe_stage_reg #(.WIDTH(64), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(16), .CNT_W(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .in_data   (in_data16),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_data  (out_data3),
        .stall_cnt (stall_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        total++; if (stall_cnt3 !== 3'd0) begin bad++; $display("FAIL reset_stall_cnt3: got %0d want 0", stall_cnt3); end
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_cycle1: got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = 64'(i);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_out_valid[%0d]: got %b want 1", i, out_valid); end
            total++; if (out_data !== 64'(i)) begin bad++; $display("FAIL stream_out_data[%0d]: got %0h want %0h", i, out_data, i); end
            total++; if (out_data3 !== 16'(i)) begin bad++; $display("FAIL stream_out_data3[%0d]: got %0h want %0h", i, out_data3, i); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 64'hA) begin bad++; $display("FAIL bp_first: valid=%b data=%0h want 1/a", out_valid, out_data); end
`ifdef PIPE_SKID_EN
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_a: got %b want 1", in_ready); end
        in_data = 64'hB;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        total++; if (out_data !== 64'hA) begin bad++; $display("FAIL bp_hold_a: got %0h want a", out_data); end
        in_data   = 64'hC;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_registered: got %b want 0", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 64'hB) begin bad++; $display("FAIL bp_second: valid=%b data=%0h want 1/b", out_valid, out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_again: got %b want 1", in_ready); end
`else
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after_a: got %b want 0", in_ready); end
        in_data = 64'hB;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        total++; if (out_data !== 64'hA) begin bad++; $display("FAIL bp_hold_a: got %0h want a", out_data); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_comb: got %b want 1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 64'hB) begin bad++; $display("FAIL bp_second: valid=%b data=%0h want 1/b", out_valid, out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_again: got %b want 1", in_ready); end
        in_data = 64'hC;
`endif
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 64'hC) begin bad++; $display("FAIL bp_third: valid=%b data=%0h want 1/c", out_valid, out_data); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL bp_stall_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h55;
        tick();
        in_data = 64'h66;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 64'h55) begin bad++; $display("FAIL flush_pre: valid=%b data=%0h want 1/55", out_valid, out_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_ready: got %b want 0", in_ready); end
        flush   = 1'b1;
        in_data = 64'h77;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL flush_stall_cnt: got %0d want 2", stall_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_leak[%0d]: valid=%b data=%0h want 0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_stall_counter();
        int exp3;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h99;
        tick();
        in_valid = 1'b0;
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stall_start: got %0d want 0", stall_cnt); end
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp3 = (n > 7) ? 7 : n;
            total++; if (stall_cnt !== 32'(n)) begin bad++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", n, stall_cnt, n); end
            total++; if (stall_cnt3 !== 3'(exp3)) begin bad++; $display("FAIL stall_cnt3[%0d]: got %0d want %0d", n, stall_cnt3, exp3); end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_flush_valid: got %b want 0", out_valid); end
        total++; if (stall_cnt !== 32'd10) begin bad++; $display("FAIL stall_flush_cnt: got %0d want 10", stall_cnt); end
        total++; if (stall_cnt3 !== 3'd7) begin bad++; $display("FAIL stall_flush_cnt3: got %0d want 7", stall_cnt3); end
        tick();
        total++; if (stall_cnt3 !== 3'd7) begin bad++; $display("FAIL stall_idle_cnt3: got %0d want 7", stall_cnt3); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1234;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 64'h1234) begin bad++; $display("FAIL arst_loaded: valid=%b data=%0h want 1/1234", out_valid, out_data); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL arst_data: got %0h want 0", out_data); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL arst_stall_cnt: got %0d want 0", stall_cnt); end
        total++; if (stall_cnt3 !== 3'd0) begin bad++; $display("FAIL arst_stall_cnt3: got %0d want 0", stall_cnt3); end
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_no_survivor: got %b want 0", out_valid); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h42;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 64'h42) begin bad++; $display("FAIL arst_first_xfer: valid=%b data=%0h want 1/42", out_valid, out_data); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_streaming();
        test_back_to_back();
        test_flush();
        test_stall_counter();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hang: report and stop if the sequence never completes.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog timeout");
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 64: payload width in bits (any fetch/decode/execute pipe struct packed to bits).
REQ-002 Parameter CNT_W, default 32: width of the stall counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 flush  input  1  synchronous kill of all held entries (branch mispredict / exception).
REQ-006 in_valid  input  1  upstream stage presents a valid payload.
REQ-007 in_ready  output  1  stage can accept a payload this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  downstream payload valid.
REQ-010 out_ready  input  1  downstream stage accepts this cycle.
REQ-011 out_data  output  WIDTH  downstream payload.
REQ-012 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-013 Transfer in: in_valid && in_ready at posedge; transfer out: out_valid && out_ready at posedge.
REQ-014 Payloads leave in acceptance order; no payload is dropped or duplicated except by flush.
REQ-015 out_data, out_valid driven directly from registers (no combinational path from in_* to out_*).
REQ-016 Latency: a payload accepted at edge N is on out_data with out_valid=1 after edge N (one cycle) when the stage was empty.
REQ-017 flush=1 at an edge: all entries invalidated, in-side transfer that cycle ignored, out_valid=0 after the edge; payload registers hold their values.
REQ-018 flush has priority over simultaneous in and out transfers.
REQ-019 out_data when out_valid=0: holds last value; not checked by the bench.
REQ-020 stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0 and flush=0.
REQ-021 stall_cnt saturates at all-ones; it does not wrap.
REQ-022 stall_cnt is cleared only by reset, never by flush.

Reset
REQ-023 reset=0 immediately (asynchronously) forces out_valid=0, out_data=0, all internal valid bits=0, stall_cnt=0.
REQ-024 After reset deassertion, in_ready=1 from the first cycle.
REQ-025 reset asserted mid-transfer discards all held payloads; no partial state survives.

Configuration
REQ-026 Macro PIPE_SKID_EN defined: 2-entry skid buffer (main + skid register), states EMPTY, ONE, TWO.
REQ-027 With PIPE_SKID_EN: in_ready = registered (not skid_valid); no combinational path out_ready -> in_ready.
REQ-028 With PIPE_SKID_EN transitions: EMPTY+in -> ONE; ONE+in+!out -> TWO (new payload into skid); ONE+in+out -> ONE (main reloaded); ONE+out+!in -> EMPTY; TWO+out -> ONE (skid moves to main); TWO with in_ready=0 accepts nothing.
REQ-029 Macro PIPE_SKID_EN undefined: single register; in_ready = !out_valid || out_ready (combinational); full throughput when out_ready=1, no TWO state.

Verification
REQ-030 Streaming: out_ready=1, in_valid=1 with data 1,2,3,...,10 on consecutive cycles -> out_data 1..10 on consecutive cycles, each one cycle after acceptance, in_ready stays 1.
REQ-031 Back-pressure (PIPE_SKID_EN): accept 0xA, 0xB with out_ready=0 -> in_ready=0 after second edge; out_ready=1 for two cycles -> outputs 0xA then 0xB, in_ready=1 again; no loss when 0xC is offered throughout.
REQ-032 Flush: stage holds 0x55 (and 0x66 in skid), flush=1 with in_valid=1, data 0x77 -> out_valid=0 next cycle, 0x77 never appears at output.
REQ-033 Stall counter: out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; with CNT_W=3 held 10 cycles -> stall_cnt=7 (saturated); flush leaves it at 7.
REQ-034 Async reset: reset=0 mid-cycle while holding 0x1234 -> out_valid=0, out_data=0, stall_cnt=0 before the next clock edge; reset=1 -> in_ready=1.
REQ-035 Build-option check: repeat REQ-030 and REQ-031 with PIPE_SKID_EN undefined -> identical output order; in_ready follows out_ready combinationally when full.
